// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared types and constants for the 7-segment display scheduler.
// Leading-zero blanking is enabled in the top level by defining SEG_LZB_EN.
package seg_disp_pkg;

  localparam int DIG_W   = 4;
  localparam int NUM_DIG = 4;
  localparam int WORD_W  = DIG_W * NUM_DIG;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_DIG [NUM_DIG] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  typedef enum logic {IDLE, SHOW} state_e;

  typedef logic [1:0]        dig_idx_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [DIG_W-1:0]  digit_t;

  function automatic digit_t digit_of(word_t w, dig_idx_t k);
    return w[{k, 2'b00} +: DIG_W];
  endfunction

  // True when digit k and every digit above it are zero.
  function automatic logic lead_zero(word_t w, dig_idx_t k);
    logic z;
    unique case (k)
      2'd3:    z = (w[15:12] == '0);
      2'd2:    z = (w[15:8] == '0);
      2'd1:    z = (w[15:4] == '0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: free-running scan counter giving digit index and frame tick.
// One frame is 2**N cycles; each digit slot is a quarter frame.
import seg_disp_pkg::*;

module seg_scan_timer #(
  parameter int N = 18
) (
  input  logic     clk,
  input  logic     reset_n,
  output dig_idx_t idx,
  output logic     frame_tick
);

  logic [N-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + N'(1);
    end
  end

  assign idx        = cnt[N-1:N-2];
  assign frame_tick = &cnt;

endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin sharing of a 4-digit 7-segment display.
// Define SEG_LZB_EN to blank leading zero digits (digit0 always shown).
import seg_disp_pkg::*;

module seg_display_scheduler #(
  parameter int N            = 18,
  parameter int DWELL_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [3:0]  an,
  output logic [3:0]  hex_out,
  output logic        blank,
  output logic        frame_tick,
  output logic        owner
);

  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW-1:0] DW_MAX = DW'(DWELL_FRAMES - 1);

  dig_idx_t        idx;
  state_e          state;
  word_t           word;
  logic            last_grant;
  logic [DW-1:0]   dwell;
  logic            dwell_done;
  logic            accept_slot;
  logic            grant;
  logic            xfer;
  logic            slot_blank;

  seg_scan_timer #(
    .N(N)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .idx        (idx),
    .frame_tick (frame_tick)
  );

  assign dwell_done  = (dwell == DW_MAX);
  assign accept_slot = frame_tick & ((state == IDLE) | dwell_done);

  // On a tie the requester that did not win last time gets the slot.
  assign grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

  assign req0_ready = accept_slot & ~grant & req0_valid;
  assign req1_ready = accept_slot &  grant & req1_valid;
  assign xfer       = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      word       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      dwell      <= '0;
    end else if (xfer) begin
      state      <= SHOW;
      word       <= grant ? req1_data : req0_data;
      owner      <= grant;
      last_grant <= grant;
      dwell      <= '0;
    end else if (frame_tick && state == SHOW && !dwell_done) begin
      dwell      <= dwell + DW'(1);
    end
  end

  always_comb begin
    slot_blank = (state == IDLE);
`ifdef SEG_LZB_EN
    if (lead_zero(word, idx)) begin
      slot_blank = 1'b1;
    end
`endif
    an      = slot_blank ? AN_OFF : AN_DIG[idx];
    hex_out = slot_blank ? 4'h0 : digit_of(word, idx);
    blank   = slot_blank;
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: directed tables, corner sequences and random
// traffic checked against a frame-level reference model (N=4, DWELL_FRAMES=2).
module tb_seg_display_scheduler;

  localparam int N     = 4;
  localparam int DWELL = 2;
  localparam int FRAME = 1 << N;
  localparam int SLOT  = FRAME / 4;

  logic        clk;
  logic        reset_n;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic [3:0]  an;
  logic [3:0]  hex_out;
  logic        blank;
  logic        frame_tick;
  logic        owner;

  seg_display_scheduler #(
    .N            (N),
    .DWELL_FRAMES (DWELL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .an         (an),
    .hex_out    (hex_out),
    .blank      (blank),
    .frame_tick (frame_tick),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle count since reset, loaded word and frames since accept.
  int          m_t;
  bit          m_loaded;
  logic [15:0] m_word;
  bit          m_owner;
  bit          m_last;
  int          m_since;
  bit          mdl_r0, mdl_r1;
  bit          dut_r0, dut_r1;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [3:0] hex;
    logic       blank;
    logic       r0;
  } vec_t;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h expected %h", name, m_t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_loaded = 0;
    m_word   = '0;
    m_owner  = 0;
    m_last   = 1;
    m_since  = 0;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Check one cycle against the model, then advance to the next negedge.
  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      int         pos, slot;
      bit         tick, can, g, e_blank;
      logic [3:0] e_an, e_hex;
      #1;
      pos  = m_t % FRAME;
      slot = pos / SLOT;
      tick = (pos == FRAME - 1);
      can  = tick && (!m_loaded || m_since >= DWELL - 1);
      if (req0_valid && req1_valid) g = ~m_last;
      else g = !req0_valid;
      mdl_r0  = can && req0_valid && !g;
      mdl_r1  = can && req1_valid && g;
      e_blank = !m_loaded;
`ifdef SEG_LZB_EN
      if (slot > 0 && (m_word >> (4 * slot)) == 0) e_blank = 1;
`endif
      e_an  = e_blank ? 4'hF : ~(4'b0001 << slot);
      e_hex = 4'(m_word >> (4 * slot));
      chk("an", 16'(an), 16'(e_an));
      chk("blank", 16'(blank), 16'(e_blank));
      if (!e_blank) chk("hex_out", 16'(hex_out), 16'(e_hex));
      chk("req0_ready", 16'(req0_ready), 16'(mdl_r0));
      chk("req1_ready", 16'(req1_ready), 16'(mdl_r1));
      chk("frame_tick", 16'(frame_tick), 16'(tick));
      chk("owner", 16'(owner), 16'(m_owner));
      dut_r0 = req0_ready;
      dut_r1 = req1_ready;
      if (mdl_r0 || mdl_r1) begin
        m_loaded = 1;
        m_word   = mdl_r1 ? req1_data : req0_data;
        m_owner  = mdl_r1;
        m_last   = mdl_r1;
        m_since  = 0;
      end else if (tick && m_loaded) begin
        m_since++;
      end
      m_t++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[12];
    vec_t lz[4];
    int   acc_t[$];
    int   acc_o[$];
    int   exp_t[4] = '{15, 47, 79, 111};
    int   exp_o[4] = '{0, 1, 0, 1};
    int   k, n1, t1, nr, t0;

    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    #2;
    chk("reset_an", 16'(an), 16'hF);
    chk("reset_blank", 16'(blank), 16'h1);
    chk("reset_hex", 16'(hex_out), 16'h0);
    chk("reset_tick", 16'(frame_tick), 16'h0);
    @(negedge clk);

    // Single requester: accept at the first frame tick, then digit0 first.
    tbl[0]  = '{0,  4'hF, 4'h0, 1'b1, 1'b0};
    tbl[1]  = '{5,  4'hF, 4'h0, 1'b1, 1'b0};
    tbl[2]  = '{14, 4'hF, 4'h0, 1'b1, 1'b0};
    tbl[3]  = '{15, 4'hF, 4'h0, 1'b1, 1'b1};
    tbl[4]  = '{16, 4'hE, 4'h4, 1'b0, 1'b0};
    tbl[5]  = '{19, 4'hE, 4'h4, 1'b0, 1'b0};
    tbl[6]  = '{20, 4'hD, 4'h3, 1'b0, 1'b0};
    tbl[7]  = '{24, 4'hB, 4'h2, 1'b0, 1'b0};
    tbl[8]  = '{28, 4'h7, 4'h1, 1'b0, 1'b0};
    tbl[9]  = '{31, 4'h7, 4'h1, 1'b0, 1'b0};
    tbl[10] = '{32, 4'hE, 4'h4, 1'b0, 1'b0};
    tbl[11] = '{35, 4'hE, 4'h4, 1'b0, 1'b0};
    do_reset();
    req0_data = 16'h1234;
    k = 0;
    while (m_t < 36) begin
      req0_valid = (m_t >= 5 && m_t <= 15);
      if (k < 12 && tbl[k].t == m_t) begin
        #1;
        chk("t2_an", 16'(an), 16'(tbl[k].an));
        chk("t2_hex", 16'(hex_out), 16'(tbl[k].hex));
        chk("t2_blank", 16'(blank), 16'(tbl[k].blank));
        chk("t2_ready", 16'(req0_ready), 16'(tbl[k].r0));
        k++;
      end
      cyc(1);
    end

    // Both requesters always valid: alternate owners every dwell period.
    do_reset();
    req0_valid = 1; req0_data = 16'h1111;
    req1_valid = 1; req1_data = 16'h2222;
    while (m_t < 128) begin
      cyc(1);
      if (dut_r0 || dut_r1) begin
        acc_t.push_back(m_t - 1);
        acc_o.push_back(dut_r1 ? 1 : 0);
      end
    end
    chk("t3_count", 16'(acc_t.size()), 16'd4);
    for (int i = 0; i < 4 && i < acc_t.size(); i++) begin
      chk("t3_time", 16'(acc_t[i]), 16'(exp_t[i]));
      chk("t3_owner", 16'(acc_o[i]), 16'(exp_o[i]));
    end

    // Late req1 waits for the dwell-expiry tick.
    do_reset();
    req0_data = 16'hABCD;
    req1_data = 16'h5678;
    n1 = 0; t1 = -1;
    while (m_t < 64) begin
      req0_valid = (m_t <= 15);
      req1_valid = (m_t >= 18 && n1 == 0);
      cyc(1);
      if (dut_r1) begin n1++; t1 = m_t - 1; end
    end
    chk("t4_pulses", 16'(n1), 16'd1);
    chk("t4_time", 16'(t1), 16'd47);
    chk("t4_owner", 16'(owner), 16'd1);

    // Ten idle frames: nothing moves; then a new valid takes the next tick.
    req1_valid = 0;
    nr = 0;
    while (m_t < 224) begin
      cyc(1);
      if (dut_r0 || dut_r1) nr++;
    end
    chk("t5_no_ready", 16'(nr), 16'd0);
    #1;
    chk("t5_owner", 16'(owner), 16'd1);
    chk("t5_hex", 16'(hex_out), 16'h8);
    chk("t5_an", 16'(an), 16'hE);
    req0_data = 16'h0042;
    t0 = -1;
    while (m_t < 241) begin
      req0_valid = (m_t >= 230 && t0 < 0);
      cyc(1);
      if (dut_r0) t0 = m_t - 1;
    end
    chk("t5_next_tick", 16'(t0), 16'd239);
    chk("t5_new_owner", 16'(owner), 16'd0);

    // Word with leading zeros.
`ifdef SEG_LZB_EN
    lz[0] = '{16, 4'hE, 4'h0, 1'b0, 1'b0};
    lz[1] = '{20, 4'hD, 4'h5, 1'b0, 1'b0};
    lz[2] = '{24, 4'hF, 4'h0, 1'b1, 1'b0};
    lz[3] = '{28, 4'hF, 4'h0, 1'b1, 1'b0};
`else
    lz[0] = '{16, 4'hE, 4'h0, 1'b0, 1'b0};
    lz[1] = '{20, 4'hD, 4'h5, 1'b0, 1'b0};
    lz[2] = '{24, 4'hB, 4'h0, 1'b0, 1'b0};
    lz[3] = '{28, 4'h7, 4'h0, 1'b0, 1'b0};
`endif
    do_reset();
    req0_data = 16'h0050;
    k = 0;
    while (m_t < 38) begin
      req0_valid = (m_t <= 15);
      if (k < 4 && lz[k].t == m_t) begin
        #1;
        chk("t6_an", 16'(an), 16'(lz[k].an));
        chk("t6_blank", 16'(blank), 16'(lz[k].blank));
        if (!lz[k].blank) chk("t6_hex", 16'(hex_out), 16'(lz[k].hex));
        k++;
      end
      cyc(1);
    end

    // Asynchronous reset mid-frame while showing a word.
    req0_valid = 1; req0_data = 16'h9999;
    #3;
    reset_n = 0;
    #1;
    chk("t1_an", 16'(an), 16'hF);
    chk("t1_blank", 16'(blank), 16'h1);
    chk("t1_hex", 16'(hex_out), 16'h0);
    chk("t1_r0", 16'(req0_ready), 16'h0);
    chk("t1_r1", 16'(req1_ready), 16'h0);
    chk("t1_tick", 16'(frame_tick), 16'h0);
    chk("t1_owner", 16'(owner), 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    model_reset();
    t0 = -1;
    while (m_t < 17) begin
      cyc(1);
      if (dut_r0 && t0 < 0) t0 = m_t - 1;
    end
    chk("t1_restart", 16'(t0), 16'd15);

    // Random traffic against the model; requesters hold data until accepted.
    do_reset();
    mdl_r0 = 0; mdl_r1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (req0_valid && mdl_r0) req0_valid = 0;
      else if (req0_valid && $urandom_range(39) == 0) req0_valid = 0;
      else if (!req0_valid && $urandom_range(7) == 0) begin
        req0_valid = 1;
        req0_data  = 16'($urandom);
      end
      if (req1_valid && mdl_r1) req1_valid = 0;
      else if (req1_valid && $urandom_range(39) == 0) req1_valid = 0;
      else if (!req1_valid && $urandom_range(7) == 0) begin
        req1_valid = 1;
        req1_data  = 16'($urandom);
      end
      mdl_r0 = 0; mdl_r1 = 0;
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
